// File: rtl/hub_slot_sched.sv
// hub_slot_sched: round-robin hub slot scheduler for 8 cogs.
// Generates ena_bus / one-hot bus_sel / slot. Predicts each bus_ack from the
// requests granted ACK_LAT slots earlier and raises a sticky ack_err on mismatch.
// Optional feature macro: HUB_SLOT_STEP_EN (adds step_mode/step single-slot stepping).
module hub_slot_sched #(
   parameter int unsigned ENA_DIV = 2,
   parameter int unsigned ACK_LAT = 2
) (
   input  logic       clk_cog,
   input  logic       nres,
   input  logic [7:0] cog_req,
   input  logic [7:0] bus_ack,
   input  logic       err_clr,
`ifdef HUB_SLOT_STEP_EN
   input  logic       step_mode,
   input  logic       step,
`endif
   output logic       ena_bus,
   output logic [7:0] bus_sel,
   output logic [2:0] slot,
   output logic       ack_err
);

   localparam int unsigned PW = (ENA_DIV > 2) ? $clog2(ENA_DIV) : 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(ENA_DIV - 1);

   logic [PW-1:0] phase_q, phase_d;
   logic          ena_bus_q, ena_bus_d;
   logic [7:0]    bus_sel_q, bus_sel_d;
   logic [2:0]    slot_q, slot_d;
   logic          ack_err_q, ack_err_d;
   logic [7:0]    exp_q [ACK_LAT];
   logic [7:0]    exp_d [ACK_LAT];

   // Next-state: phase counter, slot rotation, ack expectation pipe and error flag.
   always_comb begin
      phase_d   = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
      // ena_bus is registered, so it is derived from the phase value being loaded.
      ena_bus_d = (phase_d == PHASE_LAST);
`ifdef HUB_SLOT_STEP_EN
      // Stepping parks the phase at 0 so leaving step mode starts a fresh period.
      if (step_mode) begin
         phase_d   = '0;
         ena_bus_d = step;
      end
`endif
      bus_sel_d = bus_sel_q;
      slot_d    = slot_q;
      exp_d     = exp_q;
      ack_err_d = ack_err_q;
      if (err_clr) begin
         ack_err_d = 1'b0;
      end
      if (ena_bus_q) begin
         bus_sel_d = {bus_sel_q[6:0], bus_sel_q[7]};
         slot_d    = slot_q + 3'd1;
         exp_d[0]  = cog_req & bus_sel_q;
         for (int unsigned i = 1; i < ACK_LAT; i++) begin
            exp_d[i] = exp_q[i-1];
         end
         // Set has priority over a coincident err_clr.
         if (bus_ack != exp_q[ACK_LAT-1]) begin
            ack_err_d = 1'b1;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_cog or negedge nres) begin
      if (!nres) begin
         phase_q   <= '0;
         ena_bus_q <= 1'b0;
         bus_sel_q <= 8'h01;
         slot_q    <= '0;
         ack_err_q <= 1'b0;
         for (int unsigned i = 0; i < ACK_LAT; i++) begin
            exp_q[i] <= '0;
         end
      end else begin
         phase_q   <= phase_d;
         ena_bus_q <= ena_bus_d;
         bus_sel_q <= bus_sel_d;
         slot_q    <= slot_d;
         ack_err_q <= ack_err_d;
         exp_q     <= exp_d;
      end
   end

   assign ena_bus = ena_bus_q;
   assign bus_sel = bus_sel_q;
   assign slot    = slot_q;
   assign ack_err = ack_err_q;

endmodule
